riscv_execute: RTL and testbench

- Execute stage of the multi-cycle RV32I core, instantiated as module `execute`.
- Takes operands, immediate, PC and the one-hot decode net from decode/register-read.
- Produces the register writeback value, the effective/target address, and the branch/jump-taken flag for the control FSM.
- The datapath is combinational; a small holding register keeps the results stable after the EXECUTE_1 state.

---
 rtl/riscv_execute.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_execute.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_execute.sv
// rtl/riscv_execute.sv - RV32I execute stage: combinational ALU/branch/address datapath with result hold register
module riscv_execute (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  state_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  input  logic [45:0] decode_net_i,
  output logic [31:0] writeback_value_o,
  output logic [31:0] address_o,
  output logic        branch_taken_o
);

  // Core FSM state code for the execute cycle.
  localparam logic [2:0] EXECUTE_1 = 3'd2;

  // One-hot decode bit indices (bits 0..8 belong to other units).
  localparam logic [5:0] IS_LUI   = 6'd9;
  localparam logic [5:0] IS_AUIPC = 6'd10;
  localparam logic [5:0] IS_JAL   = 6'd11;
  localparam logic [5:0] IS_JALR  = 6'd12;
  localparam logic [5:0] IS_BEQ   = 6'd13;
  localparam logic [5:0] IS_BNE   = 6'd14;
  localparam logic [5:0] IS_BLT   = 6'd15;
  localparam logic [5:0] IS_BGE   = 6'd16;
  localparam logic [5:0] IS_BLTU  = 6'd17;
  localparam logic [5:0] IS_BGEU  = 6'd18;
  localparam logic [5:0] IS_LB    = 6'd19;
  localparam logic [5:0] IS_LH    = 6'd20;
  localparam logic [5:0] IS_LW    = 6'd21;
  localparam logic [5:0] IS_LBU   = 6'd22;
  localparam logic [5:0] IS_LHU   = 6'd23;
  localparam logic [5:0] IS_SB    = 6'd24;
  localparam logic [5:0] IS_SH    = 6'd25;
  localparam logic [5:0] IS_SW    = 6'd26;
  localparam logic [5:0] IS_ADDI  = 6'd27;
  localparam logic [5:0] IS_SLTI  = 6'd28;
  localparam logic [5:0] IS_SLTIU = 6'd29;
  localparam logic [5:0] IS_XORI  = 6'd30;
  localparam logic [5:0] IS_ORI   = 6'd31;
  localparam logic [5:0] IS_ANDI  = 6'd32;
  localparam logic [5:0] IS_SLLI  = 6'd33;
  localparam logic [5:0] IS_SRLI  = 6'd34;
  localparam logic [5:0] IS_SRAI  = 6'd35;
  localparam logic [5:0] IS_ADD   = 6'd36;
  localparam logic [5:0] IS_SUB   = 6'd37;
  localparam logic [5:0] IS_SLL   = 6'd38;
  localparam logic [5:0] IS_SLT   = 6'd39;
  localparam logic [5:0] IS_SLTU  = 6'd40;
  localparam logic [5:0] IS_XOR   = 6'd41;
  localparam logic [5:0] IS_SRL   = 6'd42;
  localparam logic [5:0] IS_SRA   = 6'd43;
  localparam logic [5:0] IS_OR    = 6'd44;
  localparam logic [5:0] IS_AND   = 6'd45;

  logic        unused_decode_bits;
  logic [5:0]  op_idx;
  logic        op_valid;
  logic [4:0]  shamt_r;
  logic [4:0]  shamt_i;
  logic [31:0] rs1_plus_imm;
  logic [31:0] pc_plus_imm;
  logic [31:0] pc_plus_4;
  logic [31:0] exec_wb;
  logic [31:0] exec_addr;
  logic        exec_taken;
  logic        in_execute;
  logic [31:0] wb_d, wb_q;
  logic [31:0] addr_d, addr_q;
  logic        taken_d, taken_q;

  assign unused_decode_bits = ^decode_net_i[8:0];

  assign in_execute   = (state_i == EXECUTE_1);
  assign shamt_r      = rs2_val_i[4:0];
  assign shamt_i      = imm_i[4:0];
  assign rs1_plus_imm = rs1_val_i + imm_i;
  assign pc_plus_imm  = pc_i + imm_i;
  assign pc_plus_4    = pc_i + 32'd4;

  // Priority encoder: lowest set handled bit wins when decode is not one-hot.
  always_comb begin
    op_idx   = 6'd0;
    op_valid = 1'b0;
    for (int i = 45; i >= 9; i--) begin
      if (decode_net_i[i]) begin
        op_idx   = 6'(i);
        op_valid = 1'b1;
      end
    end
  end

  // Execute datapath; each op reads only the operands it architecturally uses.
  always_comb begin
    exec_wb    = 32'd0;
    exec_addr  = 32'd0;
    exec_taken = 1'b0;
    if (op_valid) begin
      case (op_idx)
        IS_LUI:   exec_wb = imm_i;
        IS_AUIPC: exec_wb = pc_plus_imm;
        IS_JAL: begin
          exec_wb    = pc_plus_4;
          exec_addr  = pc_plus_imm;
          exec_taken = 1'b1;
        end
        IS_JALR: begin
          exec_wb    = pc_plus_4;
          exec_addr  = {rs1_plus_imm[31:1], 1'b0};
          exec_taken = 1'b1;
        end
        IS_BEQ: begin
          exec_addr  = pc_plus_imm;
          exec_taken = (rs1_val_i == rs2_val_i);
        end
        IS_BNE: begin
          exec_addr  = pc_plus_imm;
          exec_taken = (rs1_val_i != rs2_val_i);
        end
        IS_BLT: begin
          exec_addr  = pc_plus_imm;
          exec_taken = ($signed(rs1_val_i) < $signed(rs2_val_i));
        end
        IS_BGE: begin
          exec_addr  = pc_plus_imm;
          exec_taken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
        end
        IS_BLTU: begin
          exec_addr  = pc_plus_imm;
          exec_taken = (rs1_val_i < rs2_val_i);
        end
        IS_BGEU: begin
          exec_addr  = pc_plus_imm;
          exec_taken = (rs1_val_i >= rs2_val_i);
        end
        IS_LB, IS_LH, IS_LW, IS_LBU, IS_LHU,
        IS_SB, IS_SH, IS_SW: exec_addr = rs1_plus_imm;
        IS_ADDI:  exec_wb = rs1_plus_imm;
        IS_SLTI:  exec_wb = {31'd0, $signed(rs1_val_i) < $signed(imm_i)};
        IS_SLTIU: exec_wb = {31'd0, rs1_val_i < imm_i};
        IS_XORI:  exec_wb = rs1_val_i ^ imm_i;
        IS_ORI:   exec_wb = rs1_val_i | imm_i;
        IS_ANDI:  exec_wb = rs1_val_i & imm_i;
        IS_SLLI:  exec_wb = rs1_val_i << shamt_i;
        IS_SRLI:  exec_wb = rs1_val_i >> shamt_i;
        IS_SRAI:  exec_wb = 32'($signed(rs1_val_i) >>> shamt_i);
        IS_ADD:   exec_wb = rs1_val_i + rs2_val_i;
        IS_SUB:   exec_wb = rs1_val_i - rs2_val_i;
        IS_SLL:   exec_wb = rs1_val_i << shamt_r;
        IS_SLT:   exec_wb = {31'd0, $signed(rs1_val_i) < $signed(rs2_val_i)};
        IS_SLTU:  exec_wb = {31'd0, rs1_val_i < rs2_val_i};
        IS_XOR:   exec_wb = rs1_val_i ^ rs2_val_i;
        IS_SRL:   exec_wb = rs1_val_i >> shamt_r;
        IS_SRA:   exec_wb = 32'($signed(rs1_val_i) >>> shamt_r);
        IS_OR:    exec_wb = rs1_val_i | rs2_val_i;
        IS_AND:   exec_wb = rs1_val_i & rs2_val_i;
        default: begin
          exec_wb    = 32'd0;
          exec_addr  = 32'd0;
          exec_taken = 1'b0;
        end
      endcase
    end
  end

  // Next hold value: capture live results during EXECUTE_1, otherwise keep.
  always_comb begin
    wb_d    = wb_q;
    addr_d  = addr_q;
    taken_d = taken_q;
    if (in_execute) begin
      wb_d    = exec_wb;
      addr_d  = exec_addr;
      taken_d = exec_taken;
    end
  end

  // Hold registers keep results stable for the states after EXECUTE_1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q    <= 32'd0;
      addr_q  <= 32'd0;
      taken_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      taken_q <= taken_d;
    end
  end

  // Live results in EXECUTE_1, held results elsewhere.
  always_comb begin
    writeback_value_o = wb_q;
    address_o         = addr_q;
    branch_taken_o    = taken_q;
    if (in_execute) begin
      writeback_value_o = exec_wb;
      address_o         = exec_addr;
      branch_taken_o    = exec_taken;
    end
  end

endmodule

// File: tb/tb_riscv_execute.sv
// tb/tb_riscv_execute.sv - directed self-checking bench for riscv_execute
module tb_riscv_execute;

  localparam logic [2:0] EXECUTE_1 = 3'd2;
  localparam logic [2:0] OTHER_ST  = 3'd0;

  localparam int LUI = 9, AUIPC = 10, JAL = 11, JALR = 12;
  localparam int BEQ = 13, BNE = 14, BLT = 15, BGE = 16, BLTU = 17, BGEU = 18;
  localparam int LB = 19, LH = 20, LW = 21, LBU = 22, LHU = 23, SB = 24, SH = 25, SW = 26;
  localparam int ADDI = 27, SLTI = 28, SLTIU = 29, XORI = 30, ORI = 31, ANDI = 32;
  localparam int SLLI = 33, SRLI = 34, SRAI = 35;
  localparam int ADD = 36, SUB = 37, SLL = 38, SLT = 39, SLTU = 40, XOR = 41;
  localparam int SRL = 42, SRA = 43, OR = 44, AND = 45;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [31:0] rs1, rs2, imm, pc;
  logic [45:0] dnet;
  logic [31:0] wb, addr;
  logic        taken;

  int errors = 0;
  int checks = 0;

  riscv_execute execute (
    .clk_i             (clk),
    .rst_i             (rst),
    .state_i           (state),
    .rs1_val_i         (rs1),
    .rs2_val_i         (rs2),
    .imm_i             (imm),
    .pc_i              (pc),
    .decode_net_i      (dnet),
    .writeback_value_o (wb),
    .address_o         (addr),
    .branch_taken_o    (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] exp_wb,
                     input logic [31:0] exp_addr, input logic exp_taken);
    checks++;
    assert (wb === exp_wb) else begin
      errors++;
      $error("FAIL %s wb: got %h want %h", tag, wb, exp_wb);
    end
    checks++;
    assert (addr === exp_addr) else begin
      errors++;
      $error("FAIL %s addr: got %h want %h", tag, addr, exp_addr);
    end
    checks++;
    assert (taken === exp_taken) else begin
      errors++;
      $error("FAIL %s taken: got %b want %b", tag, taken, exp_taken);
    end
  endtask

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    state = EXECUTE_1;
    dnet  = 46'd1 << op;
    rs1   = a;
    rs2   = b;
    imm   = i;
    pc    = p;
    @(negedge clk);
  endtask

  initial begin
    int ls_ops[8];
    ls_ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    rst = 1'b1; state = OTHER_ST; dnet = '0;
    rs1 = 32'h1234; rs2 = 32'h5678; imm = 32'h9; pc = 32'h100;
    #3;
    chk("reset", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    drive(ADDI,  32'd1, 32'hx, 32'd4, 32'd0);          chk("addi_xrs2", 32'd5, 0, 0);
    drive(SUB,   32'd1, 32'd3, 32'd0, 32'd0);          chk("sub", 32'hFFFFFFFE, 0, 0);
    drive(SLL,   32'd2, 32'd2, 32'd0, 32'd0);          chk("sll", 32'd8, 0, 0);
    drive(SLL,   32'd1, 32'h21, 32'd0, 32'd0);         chk("sll_shamt5", 32'd2, 0, 0);
    drive(SRA,   32'd8, 32'd1, 32'd0, 32'd0);          chk("sra", 32'd4, 0, 0);
    drive(SRA,   32'h80000000, 32'd4, 32'd0, 32'd0);   chk("sra_neg", 32'hF8000000, 0, 0);
    drive(SRL,   32'h80000000, 32'd4, 32'd0, 32'd0);   chk("srl", 32'h08000000, 0, 0);
    drive(SRAI,  32'h80000000, 32'hx, 32'h404, 32'd0); chk("srai", 32'hF8000000, 0, 0);
    drive(SLT,   32'hFFFFFFFF, 32'd2, 32'd0, 32'd0);   chk("slt", 32'd1, 0, 0);
    drive(SLTIU, 32'hFFFFFFFF, 32'hx, 32'd2, 32'd0);   chk("sltiu", 32'd0, 0, 0);
    drive(SLTU,  32'd2, 32'hFFFFFFFF, 32'd0, 32'd0);   chk("sltu", 32'd1, 0, 0);
    drive(XORI,  32'hF0F0, 32'hx, 32'h0FF0, 32'd0);    chk("xori", 32'hFF00, 0, 0);
    drive(AND,   32'hF0F0, 32'h0FF0, 32'd0, 32'd0);    chk("and", 32'h00F0, 0, 0);
    drive(AUIPC, 32'hx, 32'hx, 32'd4, 32'd0);          chk("auipc", 32'd4, 0, 0);
    drive(LUI,   32'hx, 32'hx, 32'd10, 32'd0);         chk("lui", 32'd10, 0, 0);

    drive(BEQ,  32'd1, 32'd1, 32'd4, 32'd0);           chk("beq", 32'd0, 32'd4, 1);
    drive(BNE,  32'd1, 32'd1, 32'd8, 32'd0);           chk("bne", 32'd0, 32'd8, 0);
    drive(BGE,  32'hFFFFFFFF, 32'd0, 32'd12, 32'd0);   chk("bge", 32'd0, 32'd12, 0);
    drive(BGEU, 32'hFFFFFFFF, 32'd0, 32'd12, 32'd0);   chk("bgeu", 32'd0, 32'd12, 1);
    drive(BLT,  32'hFFFFFFFF, 32'd2, 32'd16, 32'd0);   chk("blt", 32'd0, 32'd16, 1);
    drive(BLTU, 32'hFFFFFFFF, 32'd2, 32'd16, 32'd0);   chk("bltu", 32'd0, 32'd16, 0);

    for (int k = 0; k < 8; k++) begin
      drive(ls_ops[k], 32'd1, 32'h77, 32'd4, 32'd0);
      chk($sformatf("ldst%0d", ls_ops[k]), 32'd0, 32'd5, 0);
    end

    drive(JAL,  32'hx, 32'hx, 32'd4, 32'd0);           chk("jal", 32'd4, 32'd4, 1);
    drive(JALR, 32'd8, 32'hx, 32'd4, 32'd0);           chk("jalr", 32'd4, 32'd12, 1);
    drive(JALR, 32'd8, 32'hx, 32'd5, 32'd0);           chk("jalr_lsb", 32'd4, 32'd12, 1);

    @(negedge clk);
    dnet = (46'd1 << ADD) | (46'd1 << SUB);
    rs1 = 32'd7; rs2 = 32'd2;
    #1;
    chk("prio_add_sub", 32'd9, 32'd0, 0);
    dnet = (46'd1 << JAL) | (46'd1 << ADD);
    pc = 32'h40; imm = 32'h10;
    #1;
    chk("prio_jal_add", 32'h44, 32'h50, 1);

    drive(ADD, 32'd1, 32'd3, 32'd0, 32'd0);
    state = OTHER_ST; dnet = 46'd1 << SUB; rs1 = 32'd100; rs2 = 32'd1;
    #1;
    chk("hold_add", 32'd4, 32'd0, 0);
    @(negedge clk);
    chk("hold_add_2", 32'd4, 32'd0, 0);

    drive(JAL, 32'd0, 32'd0, 32'd8, 32'h20);
    state = OTHER_ST; dnet = '0;
    #1;
    chk("hold_jal", 32'h24, 32'h28, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'd0, 32'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    drive(ADD, 32'd5, 32'd6, 32'd0, 32'd0);
    dnet = '0;
    #1;
    chk("idle_none", 32'd0, 32'd0, 0);
    dnet = 46'd1 << 3;
    #1;
    chk("idle_bit3", 32'd0, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
